// File: rtl/echo_capture_pkg.sv
// rtl/echo_capture_pkg.sv - shared state encoding and sizing constants for echo_capture
package echo_capture_pkg;

    localparam int ADC_W_DEF = 8;
    localparam int DEPTH_DEF = 4096;
    localparam int AW_DEF    = 12;
    localparam int DELAY_W   = 16;
    localparam int DECIM_W   = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DELAY   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READOUT = 2'd3
    } state_t;

endpackage

// File: rtl/echo_capture_ram.sv
// rtl/echo_capture_ram.sv - simple dual-port sample buffer with one-cycle registered read
module capture_ram #(
    parameter int ADC_W = 8,
    parameter int DEPTH = 4096,
    parameter int AW    = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [ADC_W-1:0] wr_data,
    input  logic             rd_en,
    input  logic [AW-1:0]    rd_addr,
    output logic [ADC_W-1:0] rd_data
);

    logic [ADC_W-1:0] mem [DEPTH];
    logic [ADC_W-1:0] rd_data_q;

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Reset touches only the output register, so the array still maps to block RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q <= '0;
        end else if (rd_en) begin
            rd_data_q <= mem[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/echo_capture.sv
// rtl/echo_capture.sv - trigger-delayed, decimated echo window capture with peak tracking and stream readout
module echo_capture
    import echo_capture_pkg::*;
#(
    parameter int ADC_W = ADC_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic               trig,
    input  logic [DELAY_W-1:0] cfg_delay,
    input  logic [AW-1:0]      cfg_len,
    input  logic [DECIM_W-1:0] cfg_decim,
    input  logic [ADC_W-1:0]   adc_data,
    output logic [ADC_W-1:0]   out_data,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_last,
    output logic [ADC_W-1:0]   peak_val,
    output logic [AW-1:0]      peak_idx,
    output logic               peak_valid,
    output logic               busy,
    output logic               overrun
);

    localparam logic [AW-1:0]      ONE_A = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [DECIM_W-1:0] ONE_M = {{(DECIM_W-1){1'b0}}, 1'b1};
    localparam logic [DELAY_W-1:0] ONE_D = {{(DELAY_W-1){1'b0}}, 1'b1};

    state_t             state_q, state_d;
    logic               trig_d_q;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic [AW-1:0]      len_q, len_d;
    logic [DECIM_W-1:0] decim_q, decim_d;
    logic [DECIM_W-1:0] dec_q, dec_d;
    logic [AW-1:0]      idx_q, idx_d;
    logic [ADC_W-1:0]   pk_q, pk_d;
    logic [AW-1:0]      pk_idx_q, pk_idx_d;
    logic [ADC_W-1:0]   peak_val_q, peak_val_d;
    logic [AW-1:0]      peak_idx_q, peak_idx_d;
    logic               peak_valid_q, peak_valid_d;
    logic               out_valid_q, out_valid_d;
    logic               out_last_q, out_last_d;
    logic [AW-1:0]      out_idx_q, out_idx_d;
    logic               overrun_q, overrun_d;

    logic               trig_edge;
    logic [AW-1:0]      last_idx;
    logic [ADC_W-1:0]   new_pk;
    logic [AW-1:0]      new_pk_idx;
    logic               wr_en;
    logic               rd_en;

    assign trig_edge = trig & ~trig_d_q;
    assign last_idx  = len_q - ONE_A;

    // Strict greater-than keeps the earliest index on ties; sample 0 always seeds the peak.
    assign new_pk     = (idx_q == '0 || adc_data > pk_q) ? adc_data : pk_q;
    assign new_pk_idx = (idx_q == '0 || adc_data > pk_q) ? idx_q : pk_idx_q;

    always_comb begin
        state_d      = state_q;
        dly_d        = dly_q;
        len_d        = len_q;
        decim_d      = decim_q;
        dec_d        = dec_q;
        idx_d        = idx_q;
        pk_d         = pk_q;
        pk_idx_d     = pk_idx_q;
        peak_val_d   = peak_val_q;
        peak_idx_d   = peak_idx_q;
        peak_valid_d = 1'b0;
        out_valid_d  = out_valid_q;
        out_last_d   = out_last_q;
        out_idx_d    = out_idx_q;
        overrun_d    = overrun_q;
        wr_en        = 1'b0;
        rd_en        = 1'b0;

        if (trig_edge && state_q != ST_IDLE) begin
            overrun_d = 1'b1;
        end

        if (!en) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (trig_edge) begin
                        dly_d     = cfg_delay;
                        len_d     = cfg_len;
                        decim_d   = cfg_decim;
                        dec_d     = '0;
                        idx_d     = '0;
                        pk_d      = '0;
                        pk_idx_d  = '0;
                        overrun_d = 1'b0;
                        if (cfg_len != '0) begin
                            state_d = (cfg_delay == '0) ? ST_CAPTURE : ST_DELAY;
                        end
                    end
                end
                ST_DELAY: begin
                    if (dly_q <= ONE_D) begin
                        state_d = ST_CAPTURE;
                    end else begin
                        dly_d = dly_q - ONE_D;
                    end
                end
                ST_CAPTURE: begin
                    dec_d = (dec_q == decim_q) ? '0 : dec_q + ONE_M;
                    if (dec_q == '0) begin
                        wr_en    = 1'b1;
                        idx_d    = idx_q + ONE_A;
                        pk_d     = new_pk;
                        pk_idx_d = new_pk_idx;
                        if (idx_q == last_idx) begin
                            state_d      = ST_READOUT;
                            peak_val_d   = new_pk;
                            peak_idx_d   = new_pk_idx;
                            peak_valid_d = 1'b1;
                            out_valid_d  = 1'b0;
                            out_last_d   = 1'b0;
                            out_idx_d    = '0;
                        end
                    end
                end
                ST_READOUT: begin
                    // The first READOUT cycle only primes the registered RAM read of index 0.
                    if (!out_valid_q) begin
                        rd_en       = 1'b1;
                        out_valid_d = 1'b1;
                        out_last_d  = (out_idx_q == last_idx);
                    end else if (out_ready) begin
                        if (out_last_q) begin
                            state_d     = ST_IDLE;
                            out_valid_d = 1'b0;
                            out_last_d  = 1'b0;
                        end else begin
                            rd_en      = 1'b1;
                            out_idx_d  = out_idx_q + ONE_A;
                            out_last_d = (out_idx_d == last_idx);
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            trig_d_q     <= 1'b0;
            dly_q        <= '0;
            len_q        <= '0;
            decim_q      <= '0;
            dec_q        <= '0;
            idx_q        <= '0;
            pk_q         <= '0;
            pk_idx_q     <= '0;
            peak_val_q   <= '0;
            peak_idx_q   <= '0;
            peak_valid_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_last_q   <= 1'b0;
            out_idx_q    <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            trig_d_q     <= trig;
            dly_q        <= dly_d;
            len_q        <= len_d;
            decim_q      <= decim_d;
            dec_q        <= dec_d;
            idx_q        <= idx_d;
            pk_q         <= pk_d;
            pk_idx_q     <= pk_idx_d;
            peak_val_q   <= peak_val_d;
            peak_idx_q   <= peak_idx_d;
            peak_valid_q <= peak_valid_d;
            out_valid_q  <= out_valid_d;
            out_last_q   <= out_last_d;
            out_idx_q    <= out_idx_d;
            overrun_q    <= overrun_d;
        end
    end

    capture_ram #(
        .ADC_W (ADC_W),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_addr (idx_q),
        .wr_data (adc_data),
        .rd_en   (rd_en),
        .rd_addr (out_idx_d),
        .rd_data (out_data)
    );

    assign out_valid  = out_valid_q;
    assign out_last   = out_last_q;
    assign peak_val   = peak_val_q;
    assign peak_idx   = peak_idx_q;
    assign peak_valid = peak_valid_q;
    assign busy       = (state_q != ST_IDLE);
    assign overrun    = overrun_q;

endmodule

// File: doc/echo_capture.md
Name: echo_capture

Overview:
- Receive-side stage directly downstream of the transmit trigger generator. Shares its 100 MHz clock.
- On each rising edge of the trigger it waits a programmable delay, then captures a gated window of ADC echo samples into an internal buffer, with optional decimation.
- Tracks the peak amplitude inside the gate.
- Streams the captured frame out over a valid/ready interface to the host-transfer logic.
- Ignores triggers while busy and flags them as overruns.

Parameters:
- ADC_W, 8, ADC sample width in bits (unsigned).
- DEPTH, 4096, buffer depth in samples; power of two.
- AW, 12, buffer address width; log2(DEPTH).

Ports:
- clk  in  1  100 MHz system clock.
- rst  in  1  synchronous active-high reset.
- en  in  1  capture enable; low aborts any activity.
- trig  in  1  transmit pulse from the trigger generator, synchronous to clk.
- cfg_delay  in  16  cycles from trigger edge to first sample.
- cfg_len  in  AW  samples per frame (stored samples, after decimation).
- cfg_decim  in  4  keep 1 of (cfg_decim+1) ADC samples.
- adc_data  in  ADC_W  ADC sample, valid every cycle.
- out_data  out  ADC_W  frame sample.
- out_valid  out  1  out_data valid.
- out_ready  in  1  consumer accepts.
- out_last  out  1  final sample of frame, qualified by out_valid.
- peak_val  out  ADC_W  maximum sample of the last frame.
- peak_idx  out  AW  index of that maximum.
- peak_valid  out  1  one-cycle pulse when peak_val and peak_idx update.
- busy  out  1  high in any state except IDLE.
- overrun  out  1  sticky; set on a trigger edge seen while busy.

Behaviour:
- Reset (clk edge with rst=1): state IDLE. All outputs 0. Internal trig_d is 0, all counters 0.
- Edge detection: cycle T is a trigger edge when trig=1 and trig_d=0. trig_d is registered every cycle regardless of state.
- IDLE:
  - On an edge with en=1, latch cfg_delay, cfg_len and cfg_decim, clear peak, and clear sample and decimation counters.
  - If latched len=0, stay in IDLE and produce no frame and no peak_valid.
  - Else, if delay=0, go to CAPTURE; otherwise go to DELAY.
- DELAY: count down the latched delay. The first ADC sample considered is adc_data at cycle T+1+cfg_delay.
- CAPTURE:
  - Each cycle the decimation counter runs 0..decim and wraps. When it is 0, write adc_data to buffer[idx] and increment idx.
  - Peak update uses strict greater-than, so the earliest index wins ties. The initial peak is sample 0.
  - After storing sample len-1, go to READOUT the next cycle.
  - peak_valid pulses for 1 cycle in that transition cycle; peak_val and peak_idx update simultaneously and hold until the next frame.
- READOUT:
  - Buffer read latency is 1 cycle. Prefetch so out_valid asserts no later than 2 cycles after entering READOUT.
  - On a beat where out_valid=1 and out_ready=1, advance to the next index. Throughput is 1 sample/cycle when out_ready is held high.
  - While out_valid=1 and out_ready=0, out_data, out_valid and out_last hold stable.
  - out_last=1 only on index len-1.
  - On the last handshake, return to IDLE; out_valid drops the next cycle.
- Trigger edge while busy: ignored; overrun <= 1. overrun clears only on rst or on an edge accepted in IDLE.
- en=0 in any state: next cycle go to IDLE. out_valid and out_last go to 0; the partial frame is discarded; no peak_valid pulse.
- cfg_* changes mid-frame have no effect; values are latched at the trigger edge.
- Delay and decimation counters are internal, wide enough for max values, and do not wrap.

Decomposition:
- Shared package holds:
  - the state encoding (IDLE, DELAY, CAPTURE, READOUT);
  - default ADC_W, DEPTH and AW;
  - cfg field widths (16 for delay, 4 for decimation).
- One sub-module, capture_ram: a simple dual-port RAM with DEPTH x ADC_W, 1 write port, 1 registered-read port, and 1-cycle read latency. It must infer block RAM.

Test Plan:
- Basic frame: delay=10, len=8, decim=0, adc_data=cycle counter, out_ready=1 -> 8 beats equal to the counter values at T+11..T+18; out_last on beat 8; busy low after.
- Decimation and peak: delay=0, len=4, decim=2, adc sequence 5,9,1,7,7,3,2,0,0,200,... -> frame 5,7,2,200; peak_val=200, peak_idx=3; peak_valid pulses once.
- Backpressure: len=6, out_ready toggled randomly -> 6 beats in order; data held while ready=0; no dropped or duplicated beats.
- Overrun: second trigger edge during CAPTURE -> first frame unaffected; overrun=1 until the next accepted trigger in IDLE.
- Abort and zero length: en=0 mid-READOUT -> out_valid=0 next cycle, state IDLE. Then cfg_len=0 with a trigger -> busy stays 0, no out_valid, no peak_valid.
- Reset mid-CAPTURE: rst=1 for 1 cycle -> all outputs 0 at the next edge; the next trigger yields a correct full frame.
